// File: rtl/alu_display_seq.sv
// alu_display_seq: sequential WIDTH-bit two's-complement ALU with a start/busy/done
// handshake, an iterative shift-add multiplier, a double-dabble BCD converter and a
// registered, time-multiplexed four-digit seven-segment driver.
// Optional build macro ALU_DP_ERR_EN: light the digit-0 decimal point while err=1.
module alu_display_seq #(
    parameter int WIDTH       = 6,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             err,
    output logic [3:0]       anodes,
    output logic [7:0]       cathodes
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_CONV, S_DONE} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic             last_step;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [PW-1:0]    acc_q, mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic             mneg_q;
    logic [WIDTH-1:0] result_q;
    logic             rerr_q;
    logic [WIDTH-1:0] bin_q;
    logic [11:0]      bcd_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic [11:0]      disp_bcd_q;
    logic             disp_neg_q;
    logic [RW-1:0]    refresh_q;
    logic [1:0]       scan_q;
    logic [3:0]       anodes_q;
    logic [7:0]       cathodes_q;

    logic [WIDTH-1:0] sum, diff, exec_res, mul_res, next_res, next_mag, mag_a, mag_b;
    logic             exec_err, mul_err, next_err;
    logic [PW-1:0]    acc_step, prod;
    logic [11:0]      bcd_adj, bcd_nx;
    logic [7:0]       seg_cur;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (op == 3'b101) ? S_MUL : S_EXEC;
            S_EXEC:  state_d = S_CONV;
            S_MUL:   if (last_step) state_d = S_CONV;
            S_CONV:  if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Single-cycle ops, multiplier step, and operand magnitudes
    always_comb begin
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        exec_res = '0;
        exec_err = 1'b0;
        unique case (op_q)
            3'b000: begin
                exec_res = sum;
                exec_err = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                exec_res = diff;
                exec_err = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010:  exec_res = a_q & b_q;
            3'b011:  exec_res = a_q | b_q;
            3'b100:  exec_res = a_q ^ b_q;
            3'b110: begin
                exec_res = -a_q;
                exec_err = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
            end
            3'b111:  exec_res = ($signed(a_q) < $signed(b_q)) ? WIDTH'(1) : '0;
            default: exec_res = '0;
        endcase

        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod     = mneg_q ? -acc_step : acc_step;
        mul_res  = prod[WIDTH-1:0];
        // Product fits WIDTH signed only if its top WIDTH+1 bits are all equal
        mul_err  = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));

        next_res = (state_q == S_MUL) ? mul_res : exec_res;
        next_err = (state_q == S_MUL) ? mul_err : exec_err;
        next_mag = next_res[WIDTH-1] ? -next_res : next_res;
        mag_a    = a[WIDTH-1] ? -a : a;
        mag_b    = b[WIDTH-1] ? -b : b;
    end

    // Double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_nx = {bcd_adj[10:0], bin_q[WIDTH-1]};
    end

    // Operand latch, multiplier, converter and result/display registers.
    // res/err/display load on the final CONV edge so they are valid while done=1.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            mneg_q     <= 1'b0;
            result_q   <= '0;
            rerr_q     <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        acc_q    <= '0;
                        mcand_q  <= PW'(mag_a);
                        mplier_q <= mag_b;
                        mneg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                    end
                end
                S_EXEC: begin
                    result_q <= next_res;
                    rerr_q   <= next_err;
                    bin_q    <= next_mag;
                    bcd_q    <= '0;
                    cnt_q    <= '0;
                end
                S_MUL: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (last_step) begin
                        result_q <= next_res;
                        rerr_q   <= next_err;
                        bin_q    <= next_mag;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_CONV: begin
                    bcd_q <= bcd_nx;
                    bin_q <= bin_q << 1;
                    if (last_step) begin
                        cnt_q      <= '0;
                        res_q      <= result_q;
                        err_q      <= rerr_q;
                        disp_bcd_q <= bcd_nx;
                        disp_neg_q <= result_q[WIDTH-1];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Segment pattern for the digit currently selected by the scan index
    always_comb begin
        seg_cur = 8'hFF;
        unique case (scan_q)
            2'd0: begin
                seg_cur = seg7(disp_bcd_q[3:0]);
`ifdef ALU_DP_ERR_EN
                if (err_q) seg_cur[7] = 1'b0;
`endif
            end
            2'd1: seg_cur = (disp_bcd_q[11:4] == 8'd0) ? 8'hFF : seg7(disp_bcd_q[7:4]);
            2'd2: seg_cur = (disp_bcd_q[11:8] == 4'd0) ? 8'hFF : seg7(disp_bcd_q[11:8]);
            2'd3: seg_cur = disp_neg_q ? 8'hBF : 8'hFF;
            default: seg_cur = 8'hFF;
        endcase
    end

    // Refresh counter, scan index and registered anode/cathode drive
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            refresh_q  <= '0;
            scan_q     <= '0;
            anodes_q   <= 4'b1110;
            cathodes_q <= 8'hC0;
        end else begin
            if (refresh_q == RW'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                scan_q    <= scan_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
            anodes_q   <= ~(4'b0001 << scan_q);
            cathodes_q <= seg_cur;
        end
    end

    assign res      = res_q;
    assign err      = err_q;
    assign anodes   = anodes_q;
    assign cathodes = cathodes_q;

endmodule

// File: tb/tb_alu_display_seq.sv
// tb_alu_display_seq: directed and randomized operations checked against a
// behavioural integer model of the ALU, handshake timing and display scan.
module tb_alu_display_seq;

    localparam int W  = 8;
    localparam int RD = 4;
`ifdef ALU_DP_ERR_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         start;
    logic         busy, done, err;
    logic [W-1:0] res;
    logic [3:0]   anodes;
    logic [7:0]   cathodes;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_display_seq #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
        .clk_100MHz(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .res(res), .err(err),
        .anodes(anodes), .cathodes(cathodes)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Exact integer result, wrapped to W bits; err when the exact value leaves the signed range
    task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [2:0] o,
                         output logic [W-1:0] r, output logic e);
        int sa, sb, x;
        logic [31:0] xv;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        x  = 0;
        e  = 1'b0;
        case (o)
            3'd0: x = sa + sb;
            3'd1: x = sa - sb;
            3'd5: x = sa * sb;
            3'd6: x = -sa;
            3'd7: x = (sa < sb) ? 1 : 0;
            default: x = 0;
        endcase
        xv = x;
        r  = xv[W-1:0];
        if (o == 3'd2) r = ai & bi;
        if (o == 3'd3) r = ai | bi;
        if (o == 3'd4) r = ai ^ bi;
        if (o == 3'd0 || o == 3'd1 || o == 3'd5 || o == 3'd6)
            e = (x < -(1 << (W-1))) || (x > (1 << (W-1)) - 1);
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Watch the scan for a few digit periods; check every digit shown, order and period
    task automatic expect_display(input logic [W-1:0] r, input logic e);
        logic [7:0] want[4];
        int sv, mag, zeros, idx, prev_idx, since, nchg;
        logic [3:0] last_an;
        sv  = int'($signed(r));
        mag = (sv < 0) ? -sv : sv;
        want[0]    = seg_of(mag % 10);
        want[0][7] = ~(e & DP_EN);
        want[1]    = (mag >= 10)  ? seg_of((mag / 10) % 10) : 8'hFF;
        want[2]    = (mag >= 100) ? seg_of(mag / 100) : 8'hFF;
        want[3]    = (sv < 0) ? 8'hBF : 8'hFF;
        prev_idx = -1;
        since    = 0;
        nchg     = 0;
        last_an  = anodes;
        for (int k = 0; k < 4*RD + 2; k++) begin
            if (k == 0 || anodes !== last_an) begin
                zeros = 0;
                idx   = 0;
                for (int i = 0; i < 4; i++) if (anodes[i] === 1'b0) begin zeros++; idx = i; end
                check("an_onehot", zeros, 1);
                check($sformatf("cath_d%0d", idx), cathodes, want[idx]);
                if (prev_idx >= 0) begin
                    check("scan_next", idx, (prev_idx + 1) % 4);
                    nchg++;
                    if (nchg > 1) check("scan_gap", since, RD);
                end
                prev_idx = idx;
                last_an  = anodes;
                since    = 0;
            end
            @(posedge clk); #1;
            since++;
        end
    endtask

    // One operation: start pulse, scramble inputs after acceptance, optional ignored
    // start pulse in cycle 3, then check latency, single done pulse, results, display.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [2:0] oi, input bit poke);
        logic [W-1:0] er, gr;
        logic ee, ge, gb;
        int lat, cyc, first, nd;
        model(ai, bi, oi, er, ee);
        lat = (oi == 3'd5) ? 2*W + 1 : W + 2;
        @(negedge clk);
        a = ai; b = bi; op = oi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 3'($urandom_range(7));
        cyc = 1; first = -1; nd = 0; gr = '0; ge = 1'b0; gb = 1'b0;
        check("busy_after_accept", busy, 1);
        while (cyc <= lat + 2) begin
            if (done === 1'b1) begin
                nd++;
                if (first < 0) begin first = cyc; gr = res; ge = err; gb = busy; end
            end
            if (poke && cyc == 3) begin start = 1'b1; a = W'($urandom); b = W'($urandom); end
            if (poke && cyc == 4) start = 1'b0;
            if (cyc == lat + 2) break;
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("latency_op%0d", oi), first, lat);
        check("done_pulses", nd, 1);
        check($sformatf("res_op%0d", oi), gr, er);
        check($sformatf("err_op%0d", oi), ge, ee);
        check("busy_in_done", gb, 1);
        check("idle_after", busy, 0);
        check("res_hold", res, er);
        expect_display(er, ee);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   ro;
        int cyc, d0, d1;
        logic [W-1:0] r0, r1;

        reset = 1'b1; a = '0; b = '0; op = '0; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", res, 0);
        check("rst_err", err, 0);
        check("rst_anodes", anodes, 4'b1110);
        check("rst_cathodes", cathodes, 8'hC0);

        // Directed cases, including overflow boundaries
        run_op(8'd5,   8'hFD, 3'd0, 0);   //   5 + -3 = 2
        run_op(8'd127, 8'd1,  3'd0, 0);   // 127 + 1 wraps to -128, err
        run_op(8'h80,  8'd1,  3'd1, 0);   // -128 - 1 wraps, err
        run_op(8'h9C,  8'd5,  3'd1, 0);   // -100 - 5 = -105
        run_op(8'hF9,  8'd6,  3'd5, 0);   //  -7 * 6 = -42
        run_op(8'd16,  8'd16, 3'd5, 0);   //  16 * 16 = 256, err
        run_op(8'h80,  8'd1,  3'd5, 0);   // -128 * 1 fits
        run_op(8'h80,  8'h80, 3'd5, 1);   // -128 * -128, err, ignored second start
        run_op(8'h80,  8'd0,  3'd6, 0);   // -(-128), err
        run_op(8'd9,   8'd0,  3'd6, 0);
        run_op(8'hFF,  8'd1,  3'd7, 0);   // -1 < 1
        run_op(8'd1,   8'hFF, 3'd7, 0);
        run_op(8'hF0,  8'h3C, 3'd2, 0);
        run_op(8'hF0,  8'h3C, 3'd3, 0);
        run_op(8'hF0,  8'h3C, 3'd4, 0);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ro = 3'($urandom_range(7));
            run_op(ra, rb, ro, (ro == 3'd5) && ($urandom_range(1) == 1));
        end

        // start held high: re-accepted in the first IDLE cycle after DONE
        @(negedge clk);
        a = 8'd3; b = 8'd4; op = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd10; b = 8'd20;
        cyc = 1; d0 = -1; d1 = -1; r0 = '0; r1 = '0;
        while (cyc <= 2*W + 7) begin
            if (done === 1'b1) begin
                if (d0 < 0) begin d0 = cyc; r0 = res; end
                else if (d1 < 0) begin d1 = cyc; r1 = res; end
            end
            if (cyc == W + 3) check("held_idle_gap", busy, 0);
            if (cyc == W + 4) begin check("held_reaccept", busy, 1); start = 1'b0; end
            @(posedge clk); #1;
            cyc++;
        end
        check("held_done1", d0, W + 2);
        check("held_res1", r0, 7);
        check("held_done2", d1, 2*W + 5);
        check("held_res2", r1, 30);
        check("held_idle_end", busy, 0);

        // Reset in the middle of a multiply aborts it
        @(negedge clk);
        a = 8'hF9; b = 8'd6; op = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", res, 0);
        check("abort_err", err, 0);
        check("abort_anodes", anodes, 4'b1110);
        check("abort_cathodes", cathodes, 8'hC0);
        @(negedge clk); reset = 1'b0;
        d0 = 0;
        repeat (2*W + 4) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) d0++;
        end
        check("abort_quiet", d0, 0);
        expect_display('0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
